// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a single-ported register file.
// Accesses run one at a time through IDLE -> ISSUE -> (RWAIT x RD_LAT) -> DONE.
// Every FSM output is a flop, so each output is set on the edge that enters its state.
// Optional build macro: REGFILE_ARB_FIXED_PRIO_EN. When it is defined, A always wins
// contention and there is no last-served pointer. When it is undefined, arbitration
// is round-robin.
module regfile_arbiter #(
    parameter int unsigned RD_LAT = 1  // register-file read latency, 1..3
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       a_req,
    input  logic       b_req,
    input  logic       a_we,
    input  logic       b_we,
    input  logic [3:0] a_addr,
    input  logic [3:0] b_addr,
    input  logic [7:0] a_wdata,
    input  logic [7:0] b_wdata,
    output logic       a_gnt,
    output logic       b_gnt,
    output logic       a_done,
    output logic       b_done,
    output logic [7:0] a_rdata,
    output logic [7:0] b_rdata,
    output logic [3:0] rf_raddr,
    output logic [3:0] rf_waddr,
    output logic       rf_ren,
    output logic       rf_wen,
    output logic [7:0] rf_wdata,
    input  logic [7:0] rf_rdata,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StRwait, StDone} state_e;

    state_e     state_q;
    logic       win_q;   // 0 = A owns the current access, 1 = B
    logic       we_q;
    logic [1:0] cnt_q;   // remaining RWAIT cycles minus one

    logic       pick_b;
    logic       sel_we;
    logic [3:0] sel_addr;
    logic [7:0] sel_wdata;

`ifndef REGFILE_ARB_FIXED_PRIO_EN
    logic       last_q;  // 0 = A served last, 1 = B served last
`endif

    // Choose the winner among the current requests and mux in its access fields.
    always_comb begin
        pick_b = 1'b0;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        pick_b = b_req && !a_req;
`else
        pick_b = b_req && (!a_req || !last_q);
`endif
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
    end

    assign busy = (state_q != StIdle);

    // Main FSM. Pulse outputs default low, and are set on the edge that enters their state.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= StIdle;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            cnt_q    <= 2'd0;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            a_done   <= 1'b0;
            b_done   <= 1'b0;
            rf_ren   <= 1'b0;
            rf_wen   <= 1'b0;
            rf_raddr <= 4'd0;
            rf_waddr <= 4'd0;
            rf_wdata <= 8'd0;
            a_rdata  <= 8'd0;
            b_rdata  <= 8'd0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            a_gnt  <= 1'b0;
            b_gnt  <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            rf_ren <= 1'b0;
            rf_wen <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (a_req || b_req) begin
                        win_q <= pick_b;
                        we_q  <= sel_we;
                        a_gnt <= !pick_b;
                        b_gnt <= pick_b;
                        if (sel_we) begin
                            rf_wen   <= 1'b1;
                            rf_waddr <= sel_addr;
                            rf_wdata <= sel_wdata;
                        end else begin
                            rf_ren   <= 1'b1;
                            rf_raddr <= sel_addr;
                        end
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (we_q) begin
                        a_done  <= !win_q;
                        b_done  <= win_q;
                        state_q <= StDone;
                    end else begin
                        cnt_q   <= 2'(RD_LAT - 1);
                        state_q <= StRwait;
                    end
                end
                StRwait: begin
                    if (cnt_q == 2'd0) begin
                        // The last RWAIT edge: rf_rdata is valid now.
                        if (win_q) begin
                            b_rdata <= rf_rdata;
                        end else begin
                            a_rdata <= rf_rdata;
                        end
                        a_done  <= !win_q;
                        b_done  <= win_q;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                StDone: begin
`ifndef REGFILE_ARB_FIXED_PRIO_EN
                    last_q <= win_q;
`endif
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
